// File: rtl/dma_controller.sv
// dma_controller: copies 4-word device blocks into memory on a device interrupt, using BR/BG bus arbitration.
// Define DMA_CYCLE_STEAL_EN to release the bus for one cycle between blocks.
module dma_controller #(
  parameter int WORD_SIZE      = 16,
  parameter int DATA_SIZE      = 3,
  parameter int DEVICE_BIT_LEN = 2,
  parameter int IDLE_OFFSET    = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dev_interrupt,
  output logic [DEVICE_BIT_LEN-1:0] dev_offset,
  input  logic [4*WORD_SIZE-1:0]    dev_data,
  output logic                      dma_start_int,
  input  logic                      cmd_valid,
  input  logic [WORD_SIZE-1:0]      cmd_addr,
  input  logic [WORD_SIZE-1:0]      cmd_len,
  output logic                      bus_request,
  input  logic                      bus_grant,
  output logic                      mem_write,
  output logic [WORD_SIZE-1:0]      mem_addr,
  output logic [4*WORD_SIZE-1:0]    mem_data,
  input  logic                      mem_ack,
  output logic                      dma_end_int,
  output logic                      busy
);
  localparam int IW = DEVICE_BIT_LEN;
  typedef enum logic [2:0] {
    IDLE, WAIT_CMD, REQ, FETCH, WRITE, DONE
`ifdef DMA_CYCLE_STEAL_EN
    , RELEASE
`endif
  } state_t;
`ifdef DMA_CYCLE_STEAL_EN
  localparam state_t AFTER_ACK = RELEASE;
`else
  localparam state_t AFTER_ACK = FETCH;
`endif
  state_t state_q, state_d;
  logic int_q, prev_q, pend_q, pend_d;
  logic [IW-1:0] idx_q, idx_d, len_q, len_d, eff_len;
  logic [WORD_SIZE-1:0] base_q, base_d, addr_q, addr_d;
  logic [4*WORD_SIZE-1:0] data_q, data_d;
  logic evt, last;
  assign evt     = int_q & ~prev_q;
  assign eff_len = (cmd_len > WORD_SIZE'(DATA_SIZE)) ? IW'(DATA_SIZE) : cmd_len[IW-1:0];
  assign last    = (idx_q + IW'(1)) == len_q;
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | (evt && state_q != IDLE);
    idx_d   = idx_q;
    len_d   = len_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (evt || pend_q) begin
        state_d = WAIT_CMD;
        pend_d  = 1'b0;
      end
      WAIT_CMD: if (cmd_valid) begin
        base_d  = cmd_addr;
        len_d   = eff_len;
        state_d = REQ;
      end
      // a zero-length command passes through REQ without raising BR
      REQ: state_d = (len_q == '0) ? DONE : bus_grant ? FETCH : REQ;
      FETCH: if (bus_grant) begin
        data_d  = dev_data;
        addr_d  = base_q + WORD_SIZE'({idx_q, 2'b00});
        state_d = WRITE;
      end else state_d = REQ;
      WRITE: if (mem_ack) begin
        idx_d   = idx_q + IW'(1);
        state_d = last ? DONE : AFTER_ACK;
      end else if (!bus_grant) state_d = REQ;
      DONE: begin
        idx_d   = '0;
        state_d = IDLE;
      end
`ifdef DMA_CYCLE_STEAL_EN
      RELEASE: state_d = REQ;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      int_q   <= 1'b0;
      prev_q  <= 1'b0;
      pend_q  <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      int_q   <= dev_interrupt;
      prev_q  <= int_q;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  assign dma_start_int = state_q == WAIT_CMD;
  assign bus_request   = (state_q == REQ && len_q != '0) || state_q == FETCH || state_q == WRITE;
  assign mem_write     = state_q == WRITE;
  assign dma_end_int   = state_q == DONE;
  assign busy          = state_q != IDLE;
  assign dev_offset    = (state_q == FETCH) ? idx_q : IW'(IDLE_OFFSET);
  assign mem_addr      = addr_q;
  assign mem_data      = data_q;
endmodule

// File: tb/tb_dma_controller.sv
// tb_dma_controller: directed vector table plus hand sequences for stalls, BG drop, pending events and reset.
module tb_dma_controller;
  logic clk = 1'b0, reset = 1'b1, dev_interrupt = 1'b0, cmd_valid = 1'b0;
  logic [15:0] cmd_addr = '0, cmd_len = '0, mem_addr;
  logic [1:0] dev_offset;
  logic [63:0] dev_data, mem_data;
  logic dma_start_int, bus_request, bus_grant, mem_write, mem_ack, dma_end_int, busy;
  logic [63:0] storage [3];
  int checks = 0, errors = 0, cyc = 0, wcnt = 0, ack_delay = 0;
  int ends = 0, gaps = 0, br_cyc = 0, end_cyc = 0;
  bit bg_en = 1'b1;
  logic br_prev = 1'b0;
  logic [15:0] wa [$];
  logic [63:0] wd [$];
  typedef struct {
    logic [15:0]      addr;
    logic [15:0]      len;
    int               nb;
    int               ad;
    logic [2:0][15:0] ea;
  } vec_t;
  vec_t tbl [5];

  dma_controller dut (
    .clk(clk), .reset(reset), .dev_interrupt(dev_interrupt), .dev_offset(dev_offset),
    .dev_data(dev_data), .dma_start_int(dma_start_int), .cmd_valid(cmd_valid),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .bus_request(bus_request), .bus_grant(bus_grant),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .dma_end_int(dma_end_int), .busy(busy)
  );

  always #5 clk = ~clk;
  assign dev_data  = (dev_offset < 2'd3) ? storage[dev_offset] : '0;
  assign bus_grant = bus_request && bg_en;
  assign mem_ack   = mem_write && (wcnt >= ack_delay);

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    wcnt <= (mem_write && !mem_ack) ? wcnt + 1 : 0;
    if (mem_write && mem_ack) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_data);
    end
    if (dma_end_int) begin
      ends    <= ends + 1;
      end_cyc <= cyc;
    end
    if (bus_request) br_cyc <= br_cyc + 1;
    if (br_prev && !bus_request && !dma_end_int) gaps <= gaps + 1;
    br_prev <= bus_request;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig(input int k);
    return k == 0 ? dma_start_int : k == 1 ? mem_write : busy;
  endfunction

  task automatic wait_for(input int k, input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = sig(k);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout waiting, got 0 expected 1", name);
    end
  endtask

  task automatic wait_end(input int e0);
    bit ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = ends > e0;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL end_wait: timeout, got 0 expected 1");
    end
  endtask

  task automatic pulse_int();
    dev_interrupt = 1'b0;
    repeat (2) @(negedge clk);
    dev_interrupt = 1'b1;
  endtask

  task automatic do_cmd(input logic [15:0] a, input logic [15:0] l, output int c);
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    c         = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int c, n0, e0, g0, b0, eg;
    bit ok;
    ack_delay = v.ad;
    pulse_int();
    wait_for(0, "start_int", ok);
    n0 = wa.size(); e0 = ends; g0 = gaps; b0 = br_cyc;
    do_cmd(v.addr, v.len, c);
    chk("br_latency", 64'(bus_request), 64'(v.nb != 0));
    wait_end(e0);
    @(negedge clk);
    chk("end_once", 64'(ends - e0), 64'd1);
    chk("offset_idle", 64'(dev_offset), 64'd3);
    chk("n_writes", 64'(wa.size() - n0), 64'(v.nb));
    for (int i = 0; i < v.nb && n0 + i < wa.size(); i++) begin
      chk("wr_addr", 64'(wa[n0+i]), 64'(v.ea[i]));
      chk("wr_data", wd[n0+i], storage[i]);
    end
`ifdef DMA_CYCLE_STEAL_EN
    eg = (v.nb > 0) ? v.nb - 1 : 0;
`else
    eg = 0;
`endif
    chk("br_gaps", 64'(gaps - g0), 64'(eg));
    if (v.nb == 0) begin
      chk("len0_end_lat", 64'(end_cyc - c), 64'd2);
      chk("len0_no_br", 64'(br_cyc - b0), 64'd0);
    end
  endtask

  initial begin
    int c, n0, e0, hits;
    bit ok;
    logic [15:0] a;
    logic [63:0] d;
    storage[0] = 64'h1111_2222_3333_4444;
    storage[1] = 64'hAAAA_BBBB_CCCC_DDDD;
    storage[2] = 64'h0123_4567_89AB_CDEF;
    tbl[0] = '{16'h01F4, 16'd3, 3, 0, {16'h01FC, 16'h01F8, 16'h01F4}};
    tbl[1] = '{16'h0100, 16'd7, 3, 0, {16'h0108, 16'h0104, 16'h0100}};
    tbl[2] = '{16'hFFFC, 16'd2, 2, 0, {16'h0000, 16'h0000, 16'hFFFC}};
    tbl[3] = '{16'h0010, 16'd1, 1, 2, {16'h0000, 16'h0000, 16'h0010}};
    tbl[4] = '{16'h1234, 16'd0, 0, 0, '0};
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_br", 64'(bus_request), 64'd0);
    chk("rst_offset", 64'(dev_offset), 64'd3);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    ack_delay = 5;
    pulse_int();
    wait_for(0, "stall_start", ok);
    e0 = ends;
    do_cmd(16'h0040, 16'd1, c);
    wait_for(1, "stall_write", ok);
    a = mem_addr;
    d = mem_data;
    chk("stall_addr", 64'(a), 64'h0040);
    chk("stall_data", d, storage[0]);
    chk("stall_ack0", 64'(mem_ack), 64'd0);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk("stall_wr", 64'(mem_write && !mem_ack), 64'd1);
      chk("stall_addr_hold", 64'(mem_addr), 64'(a));
      chk("stall_data_hold", mem_data, d);
    end
    @(negedge clk);
    chk("stall_ack", 64'(mem_ack), 64'd1);
    wait_end(e0);

    ack_delay = 3;
    pulse_int();
    wait_for(0, "bg_start", ok);
    n0 = wa.size(); e0 = ends;
    do_cmd(16'h0200, 16'd3, c);
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      ok = mem_write && mem_addr == 16'h0204;
    end
    chk("bg_blk1_seen", 64'(ok), 64'd1);
    bg_en = 1'b0;
    @(negedge clk);
    chk("bg_drop_wr", 64'(mem_write), 64'd0);
    chk("bg_drop_br", 64'(bus_request), 64'd1);
    @(negedge clk);
    chk("bg_hold_br", 64'(bus_request), 64'd1);
    bg_en = 1'b1;
    wait_end(e0);
    chk("bg_acks", 64'(wa.size() - n0), 64'd3);
    if (wa.size() - n0 == 3) begin
      chk("bg_addr1", 64'(wa[n0+1]), 64'h0204);
      chk("bg_data1", wd[n0+1], storage[1]);
      chk("bg_addr2", 64'(wa[n0+2]), 64'h0208);
    end

    ack_delay = 15;
    pulse_int();
    wait_for(0, "pend_start", ok);
    e0 = ends;
    do_cmd(16'h0400, 16'd1, c);
    wait_for(1, "pend_write", ok);
    dev_interrupt = 1'b0;
    repeat (2) @(negedge clk);
    dev_interrupt = 1'b1;
    repeat (2) @(negedge clk);
    dev_interrupt = 1'b0;
    repeat (2) @(negedge clk);
    dev_interrupt = 1'b1;
    wait_end(e0);
    wait_for(0, "pend_restart", ok);
    chk("pend_restart", 64'(ok), 64'd1);
    e0 = ends;
    do_cmd(16'h0000, 16'd0, c);
    wait_end(e0);
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (dma_start_int) hits++;
    end
    chk("pend_once", 64'(hits), 64'd0);

    pulse_int();
    wait_for(0, "rst_start", ok);
    do_cmd(16'h0300, 16'd2, c);
    wait_for(1, "rst_write", ok);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_wr", 64'(mem_write), 64'd0);
    chk("arst_br", 64'(bus_request), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_offset", 64'(dev_offset), 64'd3);
    chk("arst_addr", 64'(mem_addr), 64'd0);
    chk("arst_data", mem_data, 64'd0);
    chk("arst_ints", 64'({dma_start_int, dma_end_int}), 64'd0);
    dev_interrupt = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 64'({busy, dma_start_int}), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
